// File: rtl/mem_stage_pkg.sv
// Shared control-select definitions for the memory stage: opcodes, funct3
// load/store size encodings, the pipeline NOP, and the FSM state encoding.
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // addi x0, x0, 0 -- the bubble handed to WB
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_RESP = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Selects the addressed byte/half of a load response word and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory requests for loads/stores,
// stalls upstream until the access completes, and registers results to WB.
// Handshake: a request transfers on a rising edge where dmem_req_valid and
// dmem_req_ready are both high; once valid is raised the address/data/mask
// stay stable (upstream holds ex_* during stall) until ready is seen.
// A load response is a single-cycle dmem_resp_valid pulse, accepted only
// in WAIT_RESP.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rd2,
  input  logic [31:0] ex_inst,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data,
  output logic        mem_stall,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_inst,
  output logic        mem_misalign,
  output mem_state_e  dbg_state
);

  mem_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic [31:0] mem_alu_q, mem_alu_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] mem_inst_q, mem_inst_d;
  logic        mem_misalign_q, mem_misalign_d;

  logic        is_load, is_store, mem_op, misaligned;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        req_valid, stall;
  logic [3:0]  we_calc;
  logic [31:0] ld_data;

  assign funct3   = ex_inst[14:12];
  assign addr_lo  = ex_alu[1:0];
  assign is_load  = (ex_inst[6:0] == OPC_LOAD);
  assign is_store = (ex_inst[6:0] == OPC_STORE);
  assign mem_op   = is_load | is_store;

  load_extract u_load_extract (
    .word   (dmem_resp_data),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // Access decode: alignment check, store lane mask and replicated data
  always_comb begin
    misaligned = 1'b0;
    we_calc    = 4'b1111;
    dmem_wdata = ex_rd2;
    case (funct3[1:0])
      2'b00: begin
        we_calc    = 4'b0001 << addr_lo;
        dmem_wdata = {4{ex_rd2[7:0]}};
      end
      2'b01: begin
        misaligned = addr_lo[0];
        we_calc    = 4'b0011 << {addr_lo[1], 1'b0};
        dmem_wdata = {2{ex_rd2[15:0]}};
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
        we_calc    = 4'b1111;
        dmem_wdata = ex_rd2;
      end
    endcase
  end

  // FSM next-state and output-register next values; bubble by default
  always_comb begin
    state_d        = state_q;
    off_d          = off_q;
    f3_d           = f3_q;
    mem_pc_d       = 32'd0;
    mem_alu_d      = 32'd0;
    mem_rdata_d    = 32'd0;
    mem_inst_d     = NOP_INST;
    mem_misalign_d = 1'b0;
    req_valid      = 1'b0;
    stall          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          mem_pc_d   = ex_pc;
          mem_alu_d  = ex_alu;
          mem_inst_d = ex_inst;
        end else if (misaligned) begin
          // dropped access: retire in one cycle as a flagged NOP
          mem_pc_d       = ex_pc;
          mem_alu_d      = ex_alu;
          mem_misalign_d = 1'b1;
        end else begin
          req_valid = 1'b1;
          if (is_store) begin
            if (dmem_req_ready) begin
              mem_pc_d   = ex_pc;
              mem_alu_d  = ex_alu;
              mem_inst_d = ex_inst;
            end else begin
              stall = 1'b1;
            end
          end else begin
            stall = 1'b1;
            if (dmem_req_ready) begin
              state_d = ST_WAIT_RESP;
              off_d   = addr_lo;
              f3_d    = funct3;
            end
          end
        end
      end
      ST_WAIT_RESP: begin
        if (dmem_resp_valid) begin
          state_d     = ST_IDLE;
          mem_pc_d    = ex_pc;
          mem_alu_d   = ex_alu;
          mem_inst_d  = ex_inst;
          mem_rdata_d = ld_data;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and WB output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      off_q          <= 2'd0;
      f3_q           <= 3'd0;
      mem_pc_q       <= 32'd0;
      mem_alu_q      <= 32'd0;
      mem_rdata_q    <= 32'd0;
      mem_inst_q     <= NOP_INST;
      mem_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      f3_q           <= f3_d;
      mem_pc_q       <= mem_pc_d;
      mem_alu_q      <= mem_alu_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_inst_q     <= mem_inst_d;
      mem_misalign_q <= mem_misalign_d;
    end
  end

  // Request/stall outputs are forced quiet while reset is asserted
  assign dmem_req_valid = req_valid & ~rst;
  assign mem_stall      = stall & ~rst;
  assign dmem_we        = (req_valid && is_store && !rst) ? we_calc : 4'b0000;
  assign dmem_addr      = {ex_alu[31:2], 2'b00};

  assign mem_pc       = mem_pc_q;
  assign mem_alu      = mem_alu_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_inst     = mem_inst_q;
  assign mem_misalign = mem_misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, stores, loads with response
// latency and backpressure, misaligned drops, and reset mid-load.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst;
  logic [31:0] ex_pc, ex_alu, ex_rd2, ex_inst;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_we;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        mem_stall;
  logic [31:0] mem_pc, mem_alu, mem_rdata, mem_inst;
  logic        mem_misalign;
  mem_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] ADDI = 32'h0550_0093;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_pc(ex_pc), .ex_alu(ex_alu), .ex_rd2(ex_rd2), .ex_inst(ex_inst),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_stall(mem_stall), .mem_pc(mem_pc), .mem_alu(mem_alu),
    .mem_rdata(mem_rdata), .mem_inst(mem_inst), .mem_misalign(mem_misalign),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [31:0] inst);
    ex_pc = pc; ex_alu = alu; ex_rd2 = rd2; ex_inst = inst;
  endtask

  initial begin
    rst = 1'b1;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0; dmem_resp_data = 32'd0;
    // aligned store held during reset: request must stay quiet
    drive(32'h10, 32'h1000, 32'h1111_2222, mk(OPC_STORE, F3_W));
    settle();
    chk("rst_inst", mem_inst, NOP_INST);
    chk("rst_pc", mem_pc, 32'd0);
    chk("rst_alu", mem_alu, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_mis", {31'd0, mem_misalign}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_we", {28'd0, dmem_we}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    step(); step();
    rst = 1'b0;

    // ADDI pass-through, stray response in IDLE ignored
    drive(32'h100, 32'h55, 32'd0, ADDI);
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'hDEAD_BEEF;
    settle();
    chk("addi_stall", {31'd0, mem_stall}, 32'd0);
    chk("addi_req", {31'd0, dmem_req_valid}, 32'd0);
    step();
    dmem_resp_valid = 1'b0;
    chk("addi_alu", mem_alu, 32'h55);
    chk("addi_pc", mem_pc, 32'h100);
    chk("addi_inst", mem_inst, ADDI);
    chk("addi_rdata", mem_rdata, 32'd0);
    chk("addi_state", 32'(dbg_state), 32'(ST_IDLE));

    // SB at 0x1003
    drive(32'h104, 32'h1003, 32'h0000_00AB, mk(OPC_STORE, F3_B));
    settle();
    chk("sb_req", {31'd0, dmem_req_valid}, 32'd1);
    chk("sb_we", {28'd0, dmem_we}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_stall", {31'd0, mem_stall}, 32'd0);
    step();
    chk("sb_inst", mem_inst, mk(OPC_STORE, F3_B));
    chk("sb_rdata", mem_rdata, 32'd0);

    // SH at 0x1002, SW at 0x1000
    drive(32'h108, 32'h1002, 32'h5555_1234, mk(OPC_STORE, F3_H));
    settle();
    chk("sh_we", {28'd0, dmem_we}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    step();
    drive(32'h10C, 32'h1000, 32'hCAFE_BABE, mk(OPC_STORE, F3_W));
    settle();
    chk("sw_we", {28'd0, dmem_we}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_BABE);
    step();

    // LH at 0x2002, response three cycles after acceptance
    drive(32'h110, 32'h2002, 32'd0, mk(OPC_LOAD, F3_H));
    exp_q.push_back(32'hFFFF_8001);
    settle();
    chk("lh_req", {31'd0, dmem_req_valid}, 32'd1);
    chk("lh_we", {28'd0, dmem_we}, 32'd0);
    chk("lh_addr", dmem_addr, 32'h2000);
    chk("lh_stall0", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lh_bub0", mem_inst, NOP_INST);
    for (int i = 1; i < 3; i++) begin
      settle();
      chk("lh_stall_w", {31'd0, mem_stall}, 32'd1);
      chk("lh_noreq", {31'd0, dmem_req_valid}, 32'd0);
      step();
      chk("lh_bub", mem_inst, NOP_INST);
    end
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h8001_1234;
    settle();
    chk("lh_stall_end", {31'd0, mem_stall}, 32'd0);
    step();
    dmem_resp_valid = 1'b0;
    chk("lh_rdata", mem_rdata, exp_q.pop_front());
    chk("lh_inst", mem_inst, mk(OPC_LOAD, F3_H));
    chk("lh_pc", mem_pc, 32'h110);

    // LW with ready low for two cycles
    drive(32'h114, 32'h2000, 32'd0, mk(OPC_LOAD, F3_W));
    exp_q.push_back(32'hCAFE_F00D);
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("lw_bp_req", {31'd0, dmem_req_valid}, 32'd1);
      chk("lw_bp_addr", dmem_addr, 32'h2000);
      chk("lw_bp_stall", {31'd0, mem_stall}, 32'd1);
      step();
      chk("lw_bp_state", 32'(dbg_state), 32'(ST_IDLE));
    end
    dmem_req_ready = 1'b1;
    settle();
    chk("lw_acc_req", {31'd0, dmem_req_valid}, 32'd1);
    step();
    chk("lw_wait_state", 32'(dbg_state), 32'(ST_WAIT_RESP));
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'hCAFE_F00D;
    settle();
    chk("lw_noreissue", {31'd0, dmem_req_valid}, 32'd0);
    chk("lw_stall_rel", {31'd0, mem_stall}, 32'd0);
    step();
    dmem_resp_valid = 1'b0;
    chk("lw_rdata", mem_rdata, exp_q.pop_front());

    // misaligned LW at 0x3001, LH at 0x2001
    drive(32'h118, 32'h3001, 32'd0, mk(OPC_LOAD, F3_W));
    settle();
    chk("mis_lw_req", {31'd0, dmem_req_valid}, 32'd0);
    chk("mis_lw_stall", {31'd0, mem_stall}, 32'd0);
    step();
    chk("mis_lw_flag", {31'd0, mem_misalign}, 32'd1);
    chk("mis_lw_inst", mem_inst, NOP_INST);
    chk("mis_lw_rdata", mem_rdata, 32'd0);
    drive(32'h11C, 32'h2001, 32'd0, mk(OPC_LOAD, F3_H));
    settle();
    chk("mis_lh_req", {31'd0, dmem_req_valid}, 32'd0);
    step();
    chk("mis_lh_flag", {31'd0, mem_misalign}, 32'd1);
    drive(32'h120, 32'h77, 32'd0, ADDI);
    step();
    chk("mis_clear", {31'd0, mem_misalign}, 32'd0);

    // LBU accepted, reset while waiting, then clean retry
    drive(32'h124, 32'h4001, 32'd0, mk(OPC_LOAD, F3_BU));
    settle();
    step();
    chk("rw_state", 32'(dbg_state), 32'(ST_WAIT_RESP));
    step();
    rst = 1'b1;
    #1;
    chk("rw_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rw_rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_rst_req", {31'd0, dmem_req_valid}, 32'd0);
    chk("rw_rst_inst", mem_inst, NOP_INST);
    step();
    rst = 1'b0;
    exp_q.push_back(32'h0000_00F0);
    settle();
    chk("rw_retry_req", {31'd0, dmem_req_valid}, 32'd1);
    step();
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h0000_F000;
    settle();
    step();
    dmem_resp_valid = 1'b0;
    chk("lbu_rdata", mem_rdata, exp_q.pop_front());

    // LB sign-extension at 0x5002
    drive(32'h128, 32'h5002, 32'd0, mk(OPC_LOAD, F3_B));
    exp_q.push_back(32'hFFFF_FF9C);
    settle();
    step();
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h119C_2233;
    settle();
    step();
    dmem_resp_valid = 1'b0;
    chk("lb_rdata", mem_rdata, exp_q.pop_front());

    drive(32'h12C, 32'd0, 32'd0, ADDI);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
